// File: rtl/card_pkg.sv
`timescale 1ns/1ps
// card_pkg: card state codes, click FSM states and the board geometry shared
// by the card controller, the hit tester and the renderer.
package card_pkg;

  localparam int N_CARDS = 12;
  localparam int COLS    = 4;
  localparam int ROWS    = 3;
  localparam int X0      = 75;
  localparam int Y0      = 45;
  localparam int CARD_W  = 140;
  localparam int CARD_H  = 150;
  localparam int GAP     = 30;

  localparam int PITCH_X = CARD_W + GAP;
  localparam int PITCH_Y = CARD_H + GAP;

  localparam int ADDR_W  = 4;
  localparam int COLOR_W = 12;
  localparam int POS_W   = 12;

  typedef enum logic [1:0] {
    CARD_EMPTY       = 2'b00,
    CARD_COVERED     = 2'b01,
    CARD_DEACTIVATED = 2'b10,
    CARD_DISCOVERED  = 2'b11
  } card_state_e;

  typedef enum logic [1:0] {
    CLICK_IDLE = 2'b00,
    CLICK_HIT  = 2'b01,
    CLICK_RESP = 2'b10,
    CLICK_HOLD = 2'b11
  } click_state_e;

  // Left pixel of column c (inclusive).
  function automatic logic [POS_W-1:0] col_left(input int c);
    return POS_W'(X0 + c * PITCH_X);
  endfunction

  // First pixel right of column c (exclusive bound).
  function automatic logic [POS_W-1:0] col_right(input int c);
    return POS_W'(X0 + c * PITCH_X + CARD_W);
  endfunction

  // Top pixel of row r (inclusive).
  function automatic logic [POS_W-1:0] row_top(input int r);
    return POS_W'(Y0 + r * PITCH_Y);
  endfunction

  // First pixel below row r (exclusive bound).
  function automatic logic [POS_W-1:0] row_bottom(input int r);
    return POS_W'(Y0 + r * PITCH_Y + CARD_H);
  endfunction

endpackage

// File: rtl/card_if.sv
`timescale 1ns/1ps
// card_if: bundle between the game FSM / colour generator / renderer (master)
// and the card controller (slave).
interface card_if;

  // colour generator loads
  logic                                            color_wr_en;
  logic [card_pkg::ADDR_W-1:0]                     color_wr_addr;
  logic [card_pkg::COLOR_W-1:0]                    color_wr_data;
  // game FSM commands
  logic                                            write_card_en;
  logic [1:0]                                      write_card_state;
  logic [card_pkg::ADDR_W-1:0]                     write_card_address;
  logic                                            update_cards_en;
  logic                                            wait_for_click_en;
  // mouse
  logic                                            mouse_left;
  logic [card_pkg::POS_W-1:0]                      mouse_xpos;
  logic [card_pkg::POS_W-1:0]                      mouse_ypos;
  // click response
  logic                                            card_pressed;
  logic [card_pkg::ADDR_W-1:0]                     card_clicked_address;
  logic [card_pkg::COLOR_W-1:0]                    card_clicked_color;
  // renderer view
  logic [2*card_pkg::N_CARDS-1:0]                  card_state_disp;
  logic [card_pkg::COLOR_W*card_pkg::N_CARDS-1:0]  card_color_disp;

  modport master (
    output color_wr_en, color_wr_addr, color_wr_data,
    output write_card_en, write_card_state, write_card_address,
    output update_cards_en, wait_for_click_en,
    output mouse_left, mouse_xpos, mouse_ypos,
    input  card_pressed, card_clicked_address, card_clicked_color,
    input  card_state_disp, card_color_disp
  );

  modport slave (
    input  color_wr_en, color_wr_addr, color_wr_data,
    input  write_card_en, write_card_state, write_card_address,
    input  update_cards_en, wait_for_click_en,
    input  mouse_left, mouse_xpos, mouse_ypos,
    output card_pressed, card_clicked_address, card_clicked_color,
    output card_state_disp, card_color_disp
  );

endinterface

// File: rtl/card_hit_test.sv
`timescale 1ns/1ps
// card_hit_test: maps a cursor position onto a card index using constant
// column/row bounds. Gaps and the area outside the grid report no hit.
module card_hit_test
  import card_pkg::*;
(
  input  logic [POS_W-1:0]  x,
  input  logic [POS_W-1:0]  y,
  output logic              hit_valid,
  output logic [ADDR_W-1:0] hit_index
);

  logic [COLS-1:0]   col_hit;
  logic [ROWS-1:0]   row_hit;
  logic [ADDR_W-1:0] col_idx;
  logic [ADDR_W-1:0] row_idx;

  genvar gi;

  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      localparam logic [POS_W-1:0] LEFT  = col_left(gi);
      localparam logic [POS_W-1:0] RIGHT = col_right(gi);
      assign col_hit[gi] = (x >= LEFT) && (x < RIGHT);
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      localparam logic [POS_W-1:0] TOP    = row_top(gi);
      localparam logic [POS_W-1:0] BOTTOM = row_bottom(gi);
      assign row_hit[gi] = (y >= TOP) && (y < BOTTOM);
    end
  endgenerate

  // Column/row hits are one-hot at most, so a plain scan encodes them.
  always_comb begin
    col_idx = '0;
    row_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_hit[c]) col_idx = ADDR_W'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_hit[r]) row_idx = ADDR_W'(r);
    end
    hit_valid = (|col_hit) && (|row_hit);
    hit_index = hit_valid ? ADDR_W'(row_idx * COLS + col_idx) : '0;
  end

endmodule

// File: rtl/card_controller.sv
`timescale 1ns/1ps
// card_controller: owns the per-card state and colour arrays, applies colour
// loads and FSM state writes, answers clicks with a one-cycle card_pressed
// pulse and keeps the renderer snapshot.
module card_controller
  import card_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  card_if.slave bus
);

  logic [1:0]               state_mem [N_CARDS];
  logic [COLOR_W-1:0]       color_mem [N_CARDS];

  logic [N_CARDS-1:0]       color_sel;
  logic [N_CARDS-1:0]       state_sel;
  logic [2*N_CARDS-1:0]     state_flat;
  logic [COLOR_W*N_CARDS-1:0] color_flat;
  logic [2*N_CARDS-1:0]     state_disp_reg;

  click_state_e             click_state_reg;
  click_state_e             click_state_next;
  logic                     mouse_left_d_reg;
  logic                     hit_valid_reg;
  logic [ADDR_W-1:0]        hit_index_reg;
  logic [ADDR_W-1:0]        clicked_address_reg;
  logic [COLOR_W-1:0]       clicked_color_reg;

  logic                     hit_valid;
  logic [ADDR_W-1:0]        hit_index;
  logic [1:0]               hit_state;
  logic [COLOR_W-1:0]       hit_color;
  logic                     mouse_rise;
  logic                     capture_hit;
  logic                     capture_resp;
  logic                     pressed;

  genvar gi;

  // Per-card write decode; out-of-range addresses match no card and are
  // therefore dropped. A colour load on the same card masks the state write.
  generate
    for (gi = 0; gi < N_CARDS; gi++) begin : g_card
      assign color_sel[gi] = bus.color_wr_en &&
                             (bus.color_wr_addr == ADDR_W'(gi));
      assign state_sel[gi] = bus.write_card_en &&
                             (bus.write_card_address == ADDR_W'(gi)) &&
                             !color_sel[gi];
      assign state_flat[2*gi +: 2]            = state_mem[gi];
      assign color_flat[COLOR_W*gi +: COLOR_W] = color_mem[gi];
    end
  endgenerate

  card_hit_test u_hit_test (
    .x         (bus.mouse_xpos),
    .y         (bus.mouse_ypos),
    .hit_valid (hit_valid),
    .hit_index (hit_index)
  );

  // Card arrays: a colour load also marks the card covered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CARDS; i++) begin
        state_mem[i] <= CARD_EMPTY;
        color_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CARDS; i++) begin
        if (color_sel[i]) begin
          color_mem[i] <= bus.color_wr_data;
          state_mem[i] <= CARD_COVERED;
        end else if (state_sel[i]) begin
          state_mem[i] <= bus.write_card_state;
        end
      end
    end
  end

  // Renderer snapshot takes the pre-write state array on update_cards_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_disp_reg <= '0;
    end else if (bus.update_cards_en) begin
      state_disp_reg <= state_flat;
    end
  end

  // Look up the registered hit card without indexing past the array.
  always_comb begin
    hit_state = CARD_EMPTY;
    hit_color = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      if (hit_index_reg == ADDR_W'(i)) begin
        hit_state = state_mem[i];
        hit_color = color_mem[i];
      end
    end
  end

  // Click FSM state register plus the hit and response capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      click_state_reg     <= CLICK_IDLE;
      mouse_left_d_reg    <= 1'b0;
      hit_valid_reg       <= 1'b0;
      hit_index_reg       <= '0;
      clicked_address_reg <= '0;
      clicked_color_reg   <= '0;
    end else begin
      click_state_reg  <= click_state_next;
      mouse_left_d_reg <= bus.mouse_left;
      if (capture_hit) begin
        hit_valid_reg <= hit_valid;
        hit_index_reg <= hit_index;
      end
      if (capture_resp) begin
        clicked_address_reg <= hit_index_reg;
        clicked_color_reg   <= hit_color;
      end
    end
  end

  // Click FSM next state: one press yields at most one pulse, and the
  // button must be released before the next press is considered.
  always_comb begin
    click_state_next = click_state_reg;
    capture_hit      = 1'b0;
    capture_resp     = 1'b0;
    pressed          = 1'b0;
    mouse_rise       = bus.mouse_left && !mouse_left_d_reg;
    case (click_state_reg)
      CLICK_IDLE: begin
        if (mouse_rise) begin
          if (bus.wait_for_click_en) begin
            capture_hit      = 1'b1;
            click_state_next = CLICK_HIT;
          end else begin
            click_state_next = CLICK_HOLD;
          end
        end
      end
      CLICK_HIT: begin
        if (hit_valid_reg && (hit_state == CARD_COVERED) &&
            bus.wait_for_click_en) begin
          capture_resp     = 1'b1;
          click_state_next = CLICK_RESP;
        end else begin
          click_state_next = CLICK_HOLD;
        end
      end
      CLICK_RESP: begin
        pressed          = 1'b1;
        click_state_next = CLICK_HOLD;
      end
      CLICK_HOLD: begin
        if (!bus.mouse_left) click_state_next = CLICK_IDLE;
      end
      default: click_state_next = CLICK_IDLE;
    endcase
  end

  assign bus.card_pressed         = pressed;
  assign bus.card_clicked_address = clicked_address_reg;
  assign bus.card_clicked_color   = clicked_color_reg;
  assign bus.card_state_disp      = state_disp_reg;
  assign bus.card_color_disp      = color_flat;

endmodule

// File: tb/tb_card_controller.sv
`timescale 1ns/1ps
// tb_card_controller: table-driven click vectors, hand-written corner
// sequences and a randomized phase checked against a behavioural board model.
module tb_card_controller;
  import card_pkg::*;

  logic clk = 1'b0;
  logic rst;

  card_if bus();

  card_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // behavioural board model
  int          m_state [N_CARDS];
  logic [11:0] m_color [N_CARDS];
  logic [23:0] m_disp;
  logic [3:0]  last_addr;
  logic [11:0] last_color;

  typedef struct {
    int   x;
    int   y;
    logic w;
    int   hold;
    logic exp_p;
    int   exp_a;
  } click_vec_t;

  click_vec_t tbl [12];

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack_state();
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < N_CARDS; i++) p[2*i +: 2] = 2'(m_state[i]);
    return p;
  endfunction

  function automatic logic [143:0] pack_color();
    logic [143:0] p;
    p = '0;
    for (int i = 0; i < N_CARDS; i++) p[12*i +: 12] = m_color[i];
    return p;
  endfunction

  // Grid hit from plain arithmetic: -1 when in a gap or outside the board.
  function automatic int ref_hit(input int x, input int y);
    int cx, cy, c, r;
    cx = x - X0;
    cy = y - Y0;
    if (cx < 0 || cy < 0) return -1;
    c = cx / (CARD_W + GAP);
    r = cy / (CARD_H + GAP);
    if (c >= COLS || r >= ROWS) return -1;
    if ((cx % (CARD_W + GAP)) >= CARD_W) return -1;
    if ((cy % (CARD_H + GAP)) >= CARD_H) return -1;
    return r * COLS + c;
  endfunction

  // Apply the current inputs to the model as the coming clock edge will.
  task automatic model_edge();
    int wa, ca;
    if (rst) begin
      for (int i = 0; i < N_CARDS; i++) begin
        m_state[i] = 0;
        m_color[i] = '0;
      end
      m_disp     = '0;
      last_addr  = '0;
      last_color = '0;
    end else begin
      if (bus.update_cards_en) m_disp = pack_state();
      ca = int'(bus.color_wr_addr);
      wa = int'(bus.write_card_address);
      if (bus.color_wr_en && ca < N_CARDS) begin
        m_color[ca] = bus.color_wr_data;
        m_state[ca] = 1;
      end
      if (bus.write_card_en && wa < N_CARDS && !(bus.color_wr_en && ca == wa))
        m_state[wa] = int'(bus.write_card_state);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.color_wr_en        = 1'b0;
    bus.color_wr_addr      = '0;
    bus.color_wr_data      = '0;
    bus.write_card_en      = 1'b0;
    bus.write_card_state   = '0;
    bus.write_card_address = '0;
    bus.update_cards_en    = 1'b0;
  endtask

  task automatic check_disp(input string tag);
    chk({tag, "_state_disp"}, 144'(bus.card_state_disp), 144'(m_disp));
    chk({tag, "_color_disp"}, bus.card_color_disp, pack_color());
  endtask

  // One full press: button down for 'hold' cycles, then released.
  task automatic press(input int x, input int y, input logic w, input int hold,
                       input logic exp_p, input int exp_a, input string name);
    $display("click %s x=%0d y=%0d wait=%0b hold=%0d expect_pulse=%0b addr=%0d",
             name, x, y, w, hold, exp_p, exp_a);
    clear_inputs();
    bus.mouse_xpos        = 12'(x);
    bus.mouse_ypos        = 12'(y);
    bus.wait_for_click_en = w;
    bus.mouse_left        = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      cycle();
      chk({name, "_pulse"}, 144'(bus.card_pressed), 144'((k == 2) && exp_p));
      if (k == 2 && exp_p) begin
        last_addr  = 4'(exp_a);
        last_color = m_color[exp_a];
        chk({name, "_addr"}, 144'(bus.card_clicked_address), 144'(last_addr));
        chk({name, "_color"}, 144'(bus.card_clicked_color), 144'(last_color));
      end
    end
    bus.mouse_left = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk({name, "_rel_pulse"}, 144'(bus.card_pressed), 144'(0));
    end
    chk({name, "_held_addr"}, 144'(bus.card_clicked_address), 144'(last_addr));
    chk({name, "_held_color"}, 144'(bus.card_clicked_color), 144'(last_color));
  endtask

  int   rx, ry, rh, rhold;
  logic rw, rexp;

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.wait_for_click_en = 1'b0;
    bus.mouse_left        = 1'b0;
    bus.mouse_xpos        = '0;
    bus.mouse_ypos        = '0;

    // reset
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_pulse", 144'(bus.card_pressed), 144'(0));
    chk("rst_addr", 144'(bus.card_clicked_address), 144'(0));
    chk("rst_color", 144'(bus.card_clicked_color), 144'(0));
    chk("rst_state_disp", 144'(bus.card_state_disp), 144'(0));
    chk("rst_color_disp", bus.card_color_disp, 144'(0));

    // colour loads; the snapshot must not move until update_cards_en
    for (int i = 0; i < N_CARDS; i++) begin
      bus.color_wr_en   = 1'b1;
      bus.color_wr_addr = 4'(i);
      bus.color_wr_data = 12'(12'h100 * i);
      cycle();
      chk("load_state_disp", 144'(bus.card_state_disp), 144'(0));
    end
    clear_inputs();
    cycle();
    check_disp("loaded");
    bus.update_cards_en = 1'b1;
    cycle();
    bus.update_cards_en = 1'b0;
    chk("update_all_covered", 144'(bus.card_state_disp), 144'(24'h555555));

    // click table
    tbl[0]  = '{300, 300, 1'b1, 100, 1'b1, 5};
    tbl[1]  = '{220, 100, 1'b1, 4,   1'b0, 0};
    tbl[2]  = '{10,  10,  1'b1, 4,   1'b0, 0};
    tbl[3]  = '{80,  50,  1'b1, 4,   1'b1, 0};
    tbl[4]  = '{600, 100, 1'b0, 4,   1'b0, 0};
    tbl[5]  = '{600, 100, 1'b1, 4,   1'b1, 3};
    tbl[6]  = '{214, 194, 1'b1, 3,   1'b1, 0};
    tbl[7]  = '{215, 100, 1'b1, 3,   1'b0, 0};
    tbl[8]  = '{245, 45,  1'b1, 3,   1'b1, 1};
    tbl[9]  = '{724, 554, 1'b1, 3,   1'b1, 11};
    tbl[10] = '{725, 554, 1'b1, 3,   1'b0, 0};
    tbl[11] = '{100, 195, 1'b1, 3,   1'b0, 0};
    for (int i = 0; i < 12; i++)
      press(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].hold, tbl[i].exp_p, tbl[i].exp_a,
            $sformatf("tbl%0d", i));

    // discovered card ignores clicks; re-covered card answers again
    clear_inputs();
    bus.write_card_en      = 1'b1;
    bus.write_card_state   = 2'b11;
    bus.write_card_address = 4'd5;
    cycle();
    clear_inputs();
    bus.update_cards_en = 1'b1;
    cycle();
    clear_inputs();
    chk("discovered_field", 144'(bus.card_state_disp[11:10]), 144'(2'b11));
    press(300, 300, 1'b1, 4, 1'b0, 0, "discovered");
    bus.write_card_en      = 1'b1;
    bus.write_card_state   = 2'b01;
    bus.write_card_address = 4'd5;
    cycle();
    clear_inputs();
    press(300, 300, 1'b1, 4, 1'b1, 5, "recovered");

    // randomized writes and clicks against the model
    for (int it = 0; it < 60; it++) begin
      rh = $urandom_range(1, 4);
      for (int k = 0; k < rh; k++) begin
        bus.color_wr_en        = ($urandom_range(0, 3) == 0);
        bus.color_wr_addr      = 4'($urandom_range(0, 15));
        bus.color_wr_data      = 12'($urandom);
        bus.write_card_en      = $urandom_range(0, 1) == 1;
        bus.write_card_state   = 2'($urandom);
        bus.write_card_address = ($urandom_range(0, 3) == 0) ? bus.color_wr_addr
                                                              : 4'($urandom_range(0, 15));
        bus.update_cards_en    = ($urandom_range(0, 2) == 0);
        cycle();
        check_disp("rand");
      end
      clear_inputs();
      rx    = $urandom_range(0, 799);
      ry    = $urandom_range(0, 599);
      rw    = ($urandom_range(0, 3) != 0);
      rhold = $urandom_range(2, 5);
      rh    = ref_hit(rx, ry);
      rexp  = rw && (rh >= 0) && (m_state[(rh >= 0) ? rh : 0] == 1);
      press(rx, ry, rw, rhold, rexp, rexp ? rh : 0, "rand");
    end

    // colour load and state write colliding on card 7
    bus.color_wr_en        = 1'b1;
    bus.color_wr_addr      = 4'd7;
    bus.color_wr_data      = 12'hABC;
    bus.write_card_en      = 1'b1;
    bus.write_card_state   = 2'b10;
    bus.write_card_address = 4'd7;
    cycle();
    clear_inputs();
    bus.update_cards_en = 1'b1;
    cycle();
    clear_inputs();
    chk("collide_state", 144'(bus.card_state_disp[15:14]), 144'(2'b01));
    chk("collide_color", 144'(bus.card_color_disp[95:84]), 144'(12'hABC));
    check_disp("collide");

    // out-of-range address leaves the board untouched
    bus.color_wr_en        = 1'b1;
    bus.color_wr_addr      = 4'd13;
    bus.color_wr_data      = 12'hFFF;
    bus.write_card_en      = 1'b1;
    bus.write_card_state   = 2'b10;
    bus.write_card_address = 4'd13;
    cycle();
    clear_inputs();
    bus.update_cards_en = 1'b1;
    cycle();
    clear_inputs();
    check_disp("addr13");

    // reset while the FSM sits in HIT
    bus.color_wr_en   = 1'b1;
    bus.color_wr_addr = 4'd5;
    bus.color_wr_data = 12'h5A5;
    cycle();
    clear_inputs();
    press(300, 300, 1'b1, 3, 1'b1, 5, "pre_reset");
    bus.mouse_xpos        = 12'd300;
    bus.mouse_ypos        = 12'd300;
    bus.wait_for_click_en = 1'b1;
    bus.mouse_left        = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("hit_rst_pulse", 144'(bus.card_pressed), 144'(0));
    chk("hit_rst_addr", 144'(bus.card_clicked_address), 144'(0));
    chk("hit_rst_color", 144'(bus.card_clicked_color), 144'(0));
    check_disp("hit_rst");
    bus.mouse_left = 1'b0;
    cycle();
    chk("hit_rst_pulse2", 144'(bus.card_pressed), 144'(0));
    rst = 1'b0;
    cycle();
    cycle();
    chk("post_rst_pulse", 144'(bus.card_pressed), 144'(0));
    chk("post_rst_addr", 144'(bus.card_clicked_address), 144'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
